// File: rtl/ssd_scan_display.sv
// Four-digit multiplexed seven-segment driver: converts a 13-bit binary value
// to BCD with a sequential shift-add-3 engine and scans the digits out.
module ssd_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LEAD_BLANK  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [12:0] num_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  anode_o,
  output logic [15:0] bcd_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DivMax = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LATCH
  } state_e;

  state_e        state_q, state_d;
  logic [12:0]   shift_q, shift_d;
  logic [12:0]   cap_q, cap_d;
  logic [12:0]   shown_q, shown_d;
  logic [15:0]   scratch_q, scratch_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    iter_q, iter_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [CW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;

  logic          startConv;
  logic [15:0]   adjusted;
  logic [3:0]    digit;
  logic          blank;

  assign startConv = !valid_q || (num_i != shown_q);

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startConv) state_d = CONV;
      CONV:    if (iter_q == 4'd12) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign adjusted = {add3(scratch_q[15:12]), add3(scratch_q[11:8]),
                     add3(scratch_q[7:4]), add3(scratch_q[3:0])};

  // The captured value is kept apart from the shift register because the
  // shifter is consumed during conversion but must still be recorded as shown.
  always_comb begin
    shift_d   = shift_q;
    cap_d     = cap_q;
    shown_d   = shown_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    valid_d   = valid_q;
    done_d    = (state_q == LATCH);
    case (state_q)
      IDLE: begin
        if (startConv) begin
          shift_d   = num_i;
          cap_d     = num_i;
          scratch_d = 16'h0000;
          iter_d    = 4'd0;
        end
      end
      CONV: begin
        scratch_d = {adjusted[14:0], shift_q[12]};
        shift_d   = {shift_q[11:0], 1'b0};
        iter_d    = iter_q + 4'd1;
      end
      LATCH: begin
        bcd_d   = scratch_q;
        shown_d = cap_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      cap_q     <= '0;
      shown_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cap_q     <= cap_d;
      shown_q   <= shown_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = done_q;
    bcd_o  = bcd_q;
    dp_o   = 1'b1;
  end

  always_comb begin
    div_d = (div_q == DivMax) ? '0 : div_q + 1'b1;
    idx_d = (div_q == DivMax) ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    digit = bcd_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      2'd2:    blank = (bcd_q[15:8] == 8'd0);
      2'd1:    blank = (bcd_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    seg_o   = (LEAD_BLANK && blank) ? 7'b1111111 : glyph(digit);
    anode_o = en_i ? ~(4'b0001 << idx_q) : 4'b1111;
  end

endmodule

// File: doc/ssd_scan_display.md
# ssd_scan_display

Drives the board's 4-digit multiplexed seven-segment display from the 13-bit debug value the CPU top level selects for the SSD. It converts the binary value to four BCD digits with a sequential shift-add-3 engine. It then time-multiplexes the digits onto shared active-low segment lines and per-digit active-low anodes, blanking leading zeros. It is the consumer at the far end of the CPU's SSD debug output and sits between the CPU top level and the board pins.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit stays lit; must be ≥ 2. Benches use 4.
- LEAD_BLANK, 1: 1 blanks leading zeros on digits 3..1; 0 shows all four digits.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  display enable; when 0, all anodes are off and conversion continues.
- num  in  13  binary value to display, 0..8191.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; tied to 1 (off).
- anode  out  4  digit enables, active-low one-hot; anode[0] is the ones digit.
- bcd  out  16  currently displayed BCD value {thousands, hundreds, tens, ones}.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; bcd has just been updated.

## Operation
- Conversion FSM states:
  - IDLE: if the `valid` flag is 0, or num ≠ `shown`, capture num into a 13-bit shift register, clear the 16-bit BCD scratch, and go to CONV. Otherwise stay in IDLE.
  - CONV: 13 iterations. Each iteration adds 3 to every scratch nibble ≥ 5, then shifts {scratch, shift} left by 1. After the 13th iteration go to LATCH.
  - LATCH: go to IDLE. On that edge: bcd ← scratch, shown ← captured value, valid ← 1, done ← 1.
- Changes on num during CONV or LATCH are ignored. They are re-evaluated in the next IDLE, so the display always converges to the latest num.
- busy = (state ≠ IDLE). done is registered and high only in the cycle after the LATCH→IDLE edge.
- Scan:
  - A div counter runs 0..REFRESH_DIV−1 and wraps.
  - On each wrap, a 2-bit digit index increments 0→1→2→3→0.
  - anode = ~(1 << index) when en = 1, and 4'b1111 when en = 0.
  - seg decodes nibble bcd[4·index+3 : 4·index].
- Glyphs (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble gives 1111111.
- Blanking (LEAD_BLANK = 1): digit k > 0 shows seg = 1111111 when every nibble at positions ≥ k is zero. Digit 0 is never blanked. Embedded zeros (e.g. 1005) are shown.
- Counter width is $clog2(REFRESH_DIV).

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, valid = 0, shown = 0, bcd = 16'h0000, done = 0, busy = 0, div = 0, index = 0, so anode = 4'b1110, seg = 1000000, dp = 1.
- Reset mid-conversion aborts the conversion immediately. The first IDLE after release recaptures num because valid = 0.
- Conversion latency, with E0 as the capturing edge (IDLE→CONV):
  - E1..E13 are the iterations; E13 enters LATCH.
  - E14 updates bcd and raises done.
  - done and the new bcd are visible in the cycle after E14.
  - busy is high in the 14 cycles between E0 and E14.
- The earliest next capture is E15, so the minimum period between done pulses is 15 cycles.
- The digit index advances once every REFRESH_DIV cycles; the first advance is REFRESH_DIV edges after reset release.
- anode and seg are combinational on the registered index, bcd and en. A bcd update changes the lit digit's glyph in the same cycle done rises.
- en toggling does not affect div, index or the FSM.

## Test plan
- Reset release with num = 0, REFRESH_DIV = 4 → done in cycle after E14 with bcd = 16'h0000. Digit 0 shows 1000000; digits 1–3 show 1111111. busy falls together with done rising.
- num = 1234 held → bcd = 16'h1234 at done. anode sequence is 1110, 1101, 1011, 0111, 4 cycles each. seg sequence is 0011001, 0110000, 0100100, 1111001.
- num = 8191 → bcd = 16'h8191. num = 1005 → digits show 1, 0, 0, 5 with no blanking.
- num = 7 with LEAD_BLANK = 1 → digits 1–3 show 1111111. With LEAD_BLANK = 0 they show 1000000.
- Capture num = 100, then change it to 200 at E5 → first done gives bcd = 16'h0100. The second capture is at E15, and the second done appears in the cycle after E29 with bcd = 16'h0200. No done occurs while num stays stable.
- Assert rst at E7 mid-conversion → all outputs take reset values immediately. After release, a full 15-edge conversion of the current num. en = 0 at any point → anode = 4'b1111 while bcd still updates.
